res_station_param: RTL and testbench
====================================

// Module: res_station_param
// PURPOSE
//  Parametrised Tomasulo reservation station (successor to the fixed alu/mul stations).
//  Holds DEPTH in-flight ops, each owning the tag BASE_LABEL+i. Entries snoop the CDB for
//  missing operands and issue one ready op per cycle to a functional unit.
//  An entry holds its tag until its own result appears on the CDB, so the tag is never reused early.
// PARAMETERS
//  DATA_W      32  operand/result width
//  LABEL_W     4   tag width; tag 0 = "operand valid, no producer"
//  OP_W        2   opcode width
//  DEPTH       3   entry count (1..8)
//  BASE_LABEL  1   tag of entry 0; requires BASE_LABEL>=1 and BASE_LABEL+DEPTH-1 <= 2^LABEL_W-1
// PORTS
//  clk                 in   1        clock, rising edge
//  RST                 in   1        synchronous reset, active-high
//  WEN                 in   1        dispatch request
//  opCode              in   OP_W     dispatched op
//  dataIn1/dataIn2     in   DATA_W   Vj/Vk
//  label1/label2       in   LABEL_W  Qj/Qk (0 = data valid)
//  BCEN                in   1        CDB valid
//  BClabel             in   LABEL_W  CDB tag
//  BCdata              in   DATA_W   CDB data
//  EXEable             in   1        FU accepts issue this cycle
//  opOut               out  OP_W     issued op
//  dataOut1/dataOut2   out  DATA_W   issued operands
//  ready_labelOut      out  LABEL_W  tag of issued entry
//  OutEn               out  1        issue valid
//  isFull              out  1        no FREE entry
//  writeable_labelOut  out  LABEL_W  tag the next dispatch receives (0 if full)
// BEHAVIOUR
//  Entry states: FREE -> WAIT (dispatch) -> EXEC (issued) -> FREE (own tag broadcast).
//  Reset: all FREE, ages 0, Q/V/op cleared; OutEn=0, isFull=0, writeable_labelOut=BASE_LABEL,
//   opOut/dataOut*/ready_labelOut=0. Reset overrides every event in the same cycle.
//  Dispatch: WEN & ~isFull -> lowest-index FREE entry becomes WAIT at the edge. WEN & isFull -> dropped,
//   with no state change, even if an entry frees the same cycle (isFull is from registered state).
//  Snoop: BCEN & BClabel==Qx of a WAIT entry -> Vx<=BCdata, Qx<=0. Dispatch bypass applies the same rule:
//   if label1/label2 matches BClabel while BCEN, capture BCdata and store Q=0.
//  Ready: WAIT with Qj==0 and Qk==0, registered state only. An operand arriving by CDB makes the entry
//   issuable the following cycle, never the same cycle.
//  Issue: OutEn, opOut, dataOut*, ready_labelOut are combinational from the selected ready entry.
//   With no ready entry, OutEn=0 and these outputs are 0. OutEn & EXEable at the edge: entry -> EXEC.
//   Without EXEable, the selection is re-evaluated each cycle (no latching).
//  Free: BCEN & BClabel==BASE_LABEL+i while entry i is EXEC -> FREE at the edge. A broadcast of an own tag
//   on a FREE/WAIT entry is ignored. Free and dispatch can hit the same entry in one cycle only if it was
//   already FREE; a just-freed entry is reusable next cycle.
//  Latency: dispatch with valid operands -> OutEn high 1 cycle later. Best case throughput 1 issue/cycle.
//  Tags outside [BASE_LABEL, BASE_LABEL+DEPTH-1] never free this station.
// CONFIGURATION
//  RS_AGE_ORDER_EN defined: issue the oldest ready entry.
//   Each entry has a clog2(DEPTH)-bit age; age=0 on dispatch; all other non-FREE ages +1 on dispatch,
//   saturating at DEPTH-1. Select the highest age, ties to the lowest index.
//  RS_AGE_ORDER_EN undefined: issue the lowest-index ready entry; no age storage.
// TESTING
//  T1 reset: RST=1 two cycles -> OutEn=0, isFull=0, writeable_labelOut=1, all data outputs 0.
//  T2 direct issue: WEN, op=2, Vj=5, Vk=7, Q=0, EXEable=1 -> next cycle OutEn=1, dataOut=5/7,
//     ready_labelOut=1; then BCEN, BClabel=1 -> entry freed, writeable_labelOut=1.
//  T3 snoop: dispatch Qj=9; later BCEN, BClabel=9, BCdata=0xDEAD -> OutEn rises exactly one cycle
//     after the broadcast, with dataOut1=0xDEAD.
//  T4 bypass: WEN, label1=9 with BCEN, BClabel=9, BCdata=0x42 in the same cycle -> next cycle OutEn=1,
//     dataOut1=0x42.
//  T5 full: DEPTH=3, three dispatches with EXEable=0 -> isFull=1, writeable_labelOut=0;
//     a fourth WEN is dropped; freeing tag 2 -> next dispatch receives tag 2.
//  T6 order: entry2 ready first, then entry0 becomes ready, EXEable=1 -> with RS_AGE_ORDER_EN,
//     entry2 (tag 3) issues first; without it, entry0 (tag 1) issues first.

Source files
------------

// File: rtl/res_station_param.sv
`default_nettype none
// ============================================================================
// Module   : res_station_param
// Brief    : Parametrised Tomasulo reservation station with CDB snoop/bypass.
//            Optional macro RS_AGE_ORDER_EN selects oldest-ready issue order.
// Revision : 1.0 - initial release
// ============================================================================
module res_station_param #(
  parameter int DATA_W     = 32,
  parameter int LABEL_W    = 4,
  parameter int OP_W       = 2,
  parameter int DEPTH      = 3,
  parameter int BASE_LABEL = 1
) (
  input  logic               clk,
  input  logic               RST,
  input  logic               WEN,
  input  logic [OP_W-1:0]    opCode,
  input  logic [DATA_W-1:0]  dataIn1,
  input  logic [DATA_W-1:0]  dataIn2,
  input  logic [LABEL_W-1:0] label1,
  input  logic [LABEL_W-1:0] label2,
  input  logic               BCEN,
  input  logic [LABEL_W-1:0] BClabel,
  input  logic [DATA_W-1:0]  BCdata,
  input  logic               EXEable,
  output logic [OP_W-1:0]    opOut,
  output logic [DATA_W-1:0]  dataOut1,
  output logic [DATA_W-1:0]  dataOut2,
  output logic [LABEL_W-1:0] ready_labelOut,
  output logic               OutEn,
  output logic               isFull,
  output logic [LABEL_W-1:0] writeable_labelOut
);
  localparam int c_IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {ST_FREE = 2'd0, ST_WAIT = 2'd1, ST_EXEC = 2'd2} state_t;

  state_t             r_state [DEPTH];
  logic [OP_W-1:0]    r_op    [DEPTH];
  logic [DATA_W-1:0]  r_vj    [DEPTH];
  logic [DATA_W-1:0]  r_vk    [DEPTH];
  logic [LABEL_W-1:0] r_qj    [DEPTH];
  logic [LABEL_W-1:0] r_qk    [DEPTH];
`ifdef RS_AGE_ORDER_EN
  localparam logic [c_IDX_W-1:0] c_AGE_MAX = c_IDX_W'(DEPTH - 1);
  logic [c_IDX_W-1:0] r_age   [DEPTH];
  logic [c_IDX_W-1:0] w_sel_age;
`endif

  logic [LABEL_W-1:0] w_tag [DEPTH];
  logic [DEPTH-1:0]   w_ready;
  logic [DEPTH-1:0]   w_free;
  logic [c_IDX_W-1:0] w_alloc_idx;
  logic [c_IDX_W-1:0] w_sel_idx;
  logic               w_sel_valid;
  logic               w_full;
  logic               w_dispatch;
  logic               w_issue;
  logic               w_byp_j;
  logic               w_byp_k;

  generate
    for (genvar g = 0; g < DEPTH; g++) begin : g_entry
      assign w_tag[g]   = LABEL_W'(BASE_LABEL + g);
      assign w_free[g]  = (r_state[g] == ST_FREE);
      assign w_ready[g] = (r_state[g] == ST_WAIT) && (r_qj[g] == '0) && (r_qk[g] == '0);
    end
  endgenerate

  assign w_full     = ~|w_free;
  assign w_dispatch = WEN & ~w_full;
  assign w_issue    = w_sel_valid & EXEable;
  assign w_byp_j    = BCEN && (label1 != '0) && (label1 == BClabel);
  assign w_byp_k    = BCEN && (label2 != '0) && (label2 == BClabel);

  assign isFull             = w_full;
  assign writeable_labelOut = w_full ? '0 : LABEL_W'(BASE_LABEL + int'(w_alloc_idx));

  // Descending scan so the lowest-index free entry wins.
  always_comb begin
    w_alloc_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (w_free[i]) w_alloc_idx = c_IDX_W'(i);
    end
  end

  always_comb begin
    w_sel_valid = 1'b0;
    w_sel_idx   = '0;
`ifdef RS_AGE_ORDER_EN
    w_sel_age   = '0;
    // Strict '>' keeps the lower index on equal ages.
    for (int i = 0; i < DEPTH; i++) begin
      if (w_ready[i] && (!w_sel_valid || (r_age[i] > w_sel_age))) begin
        w_sel_valid = 1'b1;
        w_sel_idx   = c_IDX_W'(i);
        w_sel_age   = r_age[i];
      end
    end
`else
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (w_ready[i]) begin
        w_sel_valid = 1'b1;
        w_sel_idx   = c_IDX_W'(i);
      end
    end
`endif
  end

  always_comb begin
    OutEn          = w_sel_valid;
    opOut          = '0;
    dataOut1       = '0;
    dataOut2       = '0;
    ready_labelOut = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_sel_valid && (w_sel_idx == c_IDX_W'(i))) begin
        opOut          = r_op[i];
        dataOut1       = r_vj[i];
        dataOut2       = r_vk[i];
        ready_labelOut = w_tag[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_state[i] <= ST_FREE;
        r_op[i]    <= '0;
        r_vj[i]    <= '0;
        r_vk[i]    <= '0;
        r_qj[i]    <= '0;
        r_qk[i]    <= '0;
`ifdef RS_AGE_ORDER_EN
        r_age[i]   <= '0;
`endif
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        case (r_state[i])
          ST_FREE: begin
            if (w_dispatch && (w_alloc_idx == c_IDX_W'(i))) begin
              r_state[i] <= ST_WAIT;
              r_op[i]    <= opCode;
              r_vj[i]    <= w_byp_j ? BCdata : dataIn1;
              r_vk[i]    <= w_byp_k ? BCdata : dataIn2;
              r_qj[i]    <= w_byp_j ? '0 : label1;
              r_qk[i]    <= w_byp_k ? '0 : label2;
            end
          end
          ST_WAIT: begin
            if (w_issue && (w_sel_idx == c_IDX_W'(i))) r_state[i] <= ST_EXEC;
            // Q of zero means the operand is already valid; never snoop it.
            if (BCEN && (r_qj[i] != '0) && (r_qj[i] == BClabel)) begin
              r_vj[i] <= BCdata;
              r_qj[i] <= '0;
            end
            if (BCEN && (r_qk[i] != '0) && (r_qk[i] == BClabel)) begin
              r_vk[i] <= BCdata;
              r_qk[i] <= '0;
            end
          end
          ST_EXEC: begin
            if (BCEN && (BClabel == w_tag[i])) r_state[i] <= ST_FREE;
          end
          default: r_state[i] <= ST_FREE;
        endcase
`ifdef RS_AGE_ORDER_EN
        if (w_dispatch) begin
          if (r_state[i] == ST_FREE) begin
            if (w_alloc_idx == c_IDX_W'(i)) r_age[i] <= '0;
          end else if (r_age[i] != c_AGE_MAX) begin
            r_age[i] <= r_age[i] + c_IDX_W'(1);
          end
        end
`endif
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_res_station_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_res_station_param
// Brief    : Scoreboard bench for res_station_param with a queue-based model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_res_station_param;
  localparam int DATA_W     = 32;
  localparam int LABEL_W    = 4;
  localparam int OP_W       = 2;
  localparam int DEPTH      = 3;
  localparam int BASE_LABEL = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               RST = 1'b1, WEN = 1'b0, BCEN = 1'b0, EXEable = 1'b0;
  logic [OP_W-1:0]    opCode = '0;
  logic [DATA_W-1:0]  dataIn1 = '0, dataIn2 = '0, BCdata = '0;
  logic [LABEL_W-1:0] label1 = '0, label2 = '0, BClabel = '0;
  logic [OP_W-1:0]    opOut;
  logic [DATA_W-1:0]  dataOut1, dataOut2;
  logic [LABEL_W-1:0] ready_labelOut, writeable_labelOut;
  logic               OutEn, isFull;

  res_station_param #(
    .DATA_W(DATA_W), .LABEL_W(LABEL_W), .OP_W(OP_W), .DEPTH(DEPTH), .BASE_LABEL(BASE_LABEL)
  ) dut (
    .clk(clk), .RST(RST), .WEN(WEN), .opCode(opCode),
    .dataIn1(dataIn1), .dataIn2(dataIn2), .label1(label1), .label2(label2),
    .BCEN(BCEN), .BClabel(BClabel), .BCdata(BCdata), .EXEable(EXEable),
    .opOut(opOut), .dataOut1(dataOut1), .dataOut2(dataOut2),
    .ready_labelOut(ready_labelOut), .OutEn(OutEn), .isFull(isFull),
    .writeable_labelOut(writeable_labelOut)
  );

  typedef struct packed {
    logic               en;
    logic [OP_W-1:0]    op;
    logic [DATA_W-1:0]  d1;
    logic [DATA_W-1:0]  d2;
    logic [LABEL_W-1:0] tag;
    logic               full;
    logic [LABEL_W-1:0] wl;
  } obs_t;

  obs_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  // Reference model: 0 = free, 1 = waiting, 2 = executing.
  int              m_st  [DEPTH];
  int              m_op  [DEPTH];
  logic [DATA_W-1:0] m_v1 [DEPTH];
  logic [DATA_W-1:0] m_v2 [DEPTH];
  int              m_q1  [DEPTH];
  int              m_q2  [DEPTH];
  int              m_seq [DEPTH];
  int              m_disp;

  function automatic int pick_issue();
    int best = -1;
    int bage = -1;
    for (int i = 0; i < DEPTH; i++) begin
      if (m_st[i] == 1 && m_q1[i] == 0 && m_q2[i] == 0) begin
`ifdef RS_AGE_ORDER_EN
        int a;
        a = m_disp - m_seq[i];
        if (a > DEPTH - 1) a = DEPTH - 1;
        if (a > bage) begin
          best = i;
          bage = a;
        end
`else
        if (best < 0) best = i;
`endif
      end
    end
    return best;
  endfunction

  function automatic int free_idx();
    for (int i = 0; i < DEPTH; i++) if (m_st[i] == 0) return i;
    return -1;
  endfunction

  function automatic obs_t model_obs();
    obs_t o;
    int   s;
    int   f;
    o = '0;
    s = pick_issue();
    f = free_idx();
    if (s >= 0) begin
      o.en  = 1'b1;
      o.op  = OP_W'(m_op[s]);
      o.d1  = m_v1[s];
      o.d2  = m_v2[s];
      o.tag = LABEL_W'(BASE_LABEL + s);
    end
    o.full = (f < 0);
    o.wl   = (f < 0) ? '0 : LABEL_W'(BASE_LABEL + f);
    return o;
  endfunction

  task automatic model_step(input logic rst, input logic wen, input int op,
                            input logic [DATA_W-1:0] d1, input logic [DATA_W-1:0] d2,
                            input int l1, input int l2, input logic bcen, input int bcl,
                            input logic [DATA_W-1:0] bcd, input logic exe);
    int s;
    int f;
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        m_st[i] = 0; m_op[i] = 0; m_v1[i] = '0; m_v2[i] = '0;
        m_q1[i] = 0; m_q2[i] = 0; m_seq[i] = 0;
      end
      m_disp = 0;
      return;
    end
    s = pick_issue();
    f = free_idx();
    for (int i = 0; i < DEPTH; i++) begin
      if (m_st[i] == 2) begin
        if (bcen && bcl == BASE_LABEL + i) m_st[i] = 0;
      end else if (m_st[i] == 1) begin
        if (bcen && m_q1[i] != 0 && m_q1[i] == bcl) begin m_v1[i] = bcd; m_q1[i] = 0; end
        if (bcen && m_q2[i] != 0 && m_q2[i] == bcl) begin m_v2[i] = bcd; m_q2[i] = 0; end
        if (i == s && exe) m_st[i] = 2;
      end
    end
    if (wen && f >= 0) begin
      m_st[f] = 1;
      m_op[f] = op;
      if (bcen && l1 != 0 && l1 == bcl) begin m_v1[f] = bcd; m_q1[f] = 0; end
      else begin m_v1[f] = d1; m_q1[f] = l1; end
      if (bcen && l2 != 0 && l2 == bcl) begin m_v2[f] = bcd; m_q2[f] = 0; end
      else begin m_v2[f] = d2; m_q2[f] = l2; end
      m_disp++;
      m_seq[f] = m_disp;
    end
  endtask

  // Expected outputs depend only on registered state, so they are queued right after each edge.
  task automatic drive(input logic rst, input logic wen, input int op,
                       input logic [DATA_W-1:0] d1, input logic [DATA_W-1:0] d2,
                       input int l1, input int l2, input logic bcen, input int bcl,
                       input logic [DATA_W-1:0] bcd, input logic exe);
    @(posedge clk);
    #1;
    exp_q.push_back(model_obs());
    RST = rst; WEN = wen; opCode = OP_W'(op); dataIn1 = d1; dataIn2 = d2;
    label1 = LABEL_W'(l1); label2 = LABEL_W'(l2); BCEN = bcen; BClabel = LABEL_W'(bcl);
    BCdata = bcd; EXEable = exe;
    model_step(rst, wen, op, d1, d2, l1, l2, bcen, bcl, bcd, exe);
    cyc++;
  endtask

  task automatic idle(input logic exe);
    drive(1'b0, 1'b0, 0, '0, '0, 0, 0, 1'b0, 0, '0, exe);
  endtask

  task automatic disp(input int op, input logic [DATA_W-1:0] d1, input logic [DATA_W-1:0] d2,
                      input int l1, input int l2, input logic exe);
    drive(1'b0, 1'b1, op, d1, d2, l1, l2, 1'b0, 0, '0, exe);
  endtask

  task automatic bcast(input int tag, input logic [DATA_W-1:0] d, input logic exe);
    drive(1'b0, 1'b0, 0, '0, '0, 0, 0, 1'b1, tag, d, exe);
  endtask

  initial begin : monitor
    obs_t e;
    obs_t g;
    int   n = 0;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        g.en = OutEn; g.op = opOut; g.d1 = dataOut1; g.d2 = dataOut2;
        g.tag = ready_labelOut; g.full = isFull; g.wl = writeable_labelOut;
        checks++;
        if (g !== e) begin
          errors++;
          $display("FAIL obs#%0d: got en=%0b op=%0d d1=%h d2=%h tag=%0d full=%0b wl=%0d, required en=%0b op=%0d d1=%h d2=%h tag=%0d full=%0b wl=%0d",
                   n, g.en, g.op, g.d1, g.d2, g.tag, g.full, g.wl,
                   e.en, e.op, e.d1, e.d2, e.tag, e.full, e.wl);
        end
        n++;
      end
    end
  end

  initial begin : stim
    model_step(1'b1, 1'b0, 0, '0, '0, 0, 0, 1'b0, 0, '0, 1'b0);
    // Reset held two cycles; reset state observed afterwards.
    drive(1'b1, 1'b0, 0, '0, '0, 0, 0, 1'b0, 0, '0, 1'b0);
    drive(1'b1, 1'b0, 0, '0, '0, 0, 0, 1'b0, 0, '0, 1'b0);
    idle(1'b0);
    // Direct issue, then own-tag broadcast frees the entry.
    disp(2, 32'd5, 32'd7, 0, 0, 1'b1);
    idle(1'b1);
    bcast(1, 32'h1111, 1'b0);
    idle(1'b0);
    // Snoop: issuable exactly one cycle after the broadcast.
    disp(1, 32'h0, 32'h3, 9, 0, 1'b0);
    idle(1'b0);
    bcast(9, 32'hDEAD, 1'b0);
    idle(1'b1);
    bcast(1, 32'h0, 1'b0);
    // Dispatch bypass.
    drive(1'b0, 1'b1, 3, 32'h0, 32'h8, 9, 0, 1'b1, 9, 32'h42, 1'b0);
    idle(1'b1);
    bcast(1, 32'h0, 1'b0);
    // Full station, dropped dispatch, tag 2 reuse.
    disp(0, 32'hA, 32'hB, 9, 0, 1'b0);
    disp(1, 32'hC, 32'hD, 9, 0, 1'b0);
    disp(2, 32'hE, 32'hF, 0, 9, 1'b0);
    disp(3, 32'h77, 32'h88, 0, 0, 1'b0);
    bcast(9, 32'h99, 1'b0);
    idle(1'b1);
    idle(1'b1);
    idle(1'b1);
    bcast(2, 32'h0, 1'b0);
    disp(1, 32'h5, 32'h6, 0, 0, 1'b0);
    bcast(1, 32'h0, 1'b1);
    bcast(3, 32'h0, 1'b1);
    bcast(2, 32'h0, 1'b0);
    idle(1'b0);
    // Ordering: entry0 is re-dispatched later than entry2 and becomes ready last.
    disp(0, 32'h10, 32'h11, 0, 0, 1'b0);
    disp(1, 32'h12, 32'h13, 12, 0, 1'b0);
    disp(2, 32'h14, 32'h15, 0, 0, 1'b0);
    idle(1'b1);
    bcast(1, 32'h0, 1'b0);
    disp(3, 32'h16, 32'h17, 10, 0, 1'b0);
    bcast(10, 32'h18, 1'b0);
    idle(1'b1);
    idle(1'b1);
    idle(1'b0);
    // Reset overriding a dispatch and a broadcast in the same cycle.
    drive(1'b1, 1'b1, 1, 32'h1, 32'h2, 0, 0, 1'b1, 3, 32'h3, 1'b1);
    idle(1'b0);
    // Randomised traffic.
    for (int k = 0; k < 3000; k++) begin
      logic rst_r;
      int   l1_r;
      int   l2_r;
      int   bcl_r;
      rst_r = ($urandom_range(0, 499) == 0);
      l1_r  = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 15));
      l2_r  = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 15));
      bcl_r = ($urandom_range(0, 1) == 0) ? int'($urandom_range(BASE_LABEL, BASE_LABEL + DEPTH - 1))
                                          : int'($urandom_range(0, 15));
      drive(rst_r, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), $urandom, $urandom,
            l1_r, l2_r, ($urandom_range(0, 2) != 0), bcl_r, $urandom, ($urandom_range(0, 3) != 0));
    end
    idle(1'b0);
    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expectations, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
